// File: rtl/timer_scheduler.sv
// Purpose: shares one external one-shot countdown timer among NUM_REQ requesters, round-robin, one job at a time.
// Latency: grant to done is 5 cycles minimum (LOAD, START, WAIT, ACK, DONE) plus the timer count time.
// Backpressure: level requests are held by the requester; non-granted requests simply wait until the scheduler is idle.
module timer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DELAY_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DELAY_W-1:0] delay,
    output logic [NUM_REQ-1:0]         done,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       tmr_AS_L,
    output logic                       tmr_WE_L,
    output logic                       tmr_data_sel,
    output logic                       tmr_ctrl_sel,
    output logic [31:0]                tmr_wdata,
    input  logic                       tmr_irq
);

    localparam int GW = $clog2(NUM_REQ);

    // Timer control register values: enable + irq enable to start, all zero to stop and clear.
    localparam logic [31:0] CTRL_START = 32'h0000_0003;
    localparam logic [31:0] CTRL_STOP  = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        ACK,
        DONE
    } state_t;

    state_t          state;
    logic [GW-1:0]   last_served;
    logic            completed;

    // Round-robin search results, valid only while IDLE.
    logic [GW-1:0]   rr_pick;
    logic            rr_found;
    logic [GW-1:0]   rr_cand;
    logic [DELAY_W-1:0] sel_delay;

    // Per-requester delay slices, unpacked so the grant index selects directly.
    logic [DELAY_W-1:0] delay_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_delay_split
        assign delay_arr[i] = delay[i*DELAY_W +: DELAY_W];
    end

    // Round-robin: first requesting index strictly after last_served, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        rr_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_cand = GW'((int'(last_served) + k) % NUM_REQ);
            if (!rr_found && req[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

    // Delay of the requester about to be granted; this is what the LOAD cycle writes.
    always_comb begin
        sel_delay = delay_arr[rr_pick];
    end

    // Scheduler FSM; every output is registered and set on entry to the state that presents it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= '0;
            grant_id     <= '0;
            last_served  <= GW'(NUM_REQ - 1);
            completed    <= 1'b0;
            tmr_AS_L     <= 1'b1;
            tmr_WE_L     <= 1'b1;
            tmr_data_sel <= 1'b0;
            tmr_ctrl_sel <= 1'b0;
            tmr_wdata    <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (rr_found) begin
                        // Delay is captured here, so later changes on the input cannot disturb the job.
                        state        <= LOAD;
                        busy         <= 1'b1;
                        grant_id     <= rr_pick;
                        tmr_AS_L     <= 1'b0;
                        tmr_WE_L     <= 1'b0;
                        tmr_data_sel <= 1'b1;
                        tmr_ctrl_sel <= 1'b0;
                        tmr_wdata    <= 32'(sel_delay);
                    end
                end
                LOAD: begin
                    state        <= START;
                    tmr_data_sel <= 1'b0;
                    tmr_ctrl_sel <= 1'b1;
                    tmr_wdata    <= CTRL_START;
                end
                START: begin
                    state        <= WAIT;
                    tmr_AS_L     <= 1'b1;
                    tmr_WE_L     <= 1'b1;
                    tmr_ctrl_sel <= 1'b0;
                    tmr_wdata    <= '0;
                end
                WAIT: begin
                    // Expiry wins over a simultaneous withdrawal, so a tie still completes.
                    if (tmr_irq) begin
                        completed    <= 1'b1;
                        state        <= ACK;
                        tmr_AS_L     <= 1'b0;
                        tmr_WE_L     <= 1'b0;
                        tmr_ctrl_sel <= 1'b1;
                        tmr_wdata    <= CTRL_STOP;
                    end else if (!req[grant_id]) begin
                        completed    <= 1'b0;
                        state        <= ACK;
                        tmr_AS_L     <= 1'b0;
                        tmr_WE_L     <= 1'b0;
                        tmr_ctrl_sel <= 1'b1;
                        tmr_wdata    <= CTRL_STOP;
                    end
                end
                ACK: begin
                    state           <= DONE;
                    tmr_AS_L        <= 1'b1;
                    tmr_WE_L        <= 1'b1;
                    tmr_ctrl_sel    <= 1'b0;
                    tmr_wdata       <= '0;
                    done[grant_id]  <= completed;
                end
                DONE: begin
                    // A cancelled job still advances the round-robin pointer.
                    state       <= IDLE;
                    busy        <= 1'b0;
                    last_served <= grant_id;
                    completed   <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    tmr_AS_L     <= 1'b1;
                    tmr_WE_L     <= 1'b1;
                    tmr_data_sel <= 1'b0;
                    tmr_ctrl_sel <= 1'b0;
                    tmr_wdata    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: random and directed jobs, an external one-shot timer model,
// and a scoreboard that checks every bus write and every done pulse against queued expectations.
module tb_timer_scheduler;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] delay = '0;
    logic [N-1:0]    done;
    logic            busy;
    logic [1:0]      grant_id;
    logic            tmr_AS_L;
    logic            tmr_WE_L;
    logic            tmr_data_sel;
    logic            tmr_ctrl_sel;
    logic [31:0]     tmr_wdata;
    logic            tmr_irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_ctrl;
        logic [31:0] data;
        int          gid;
    } wr_t;

    wr_t          exp_wr[$];
    int           exp_done[$];
    logic [N-1:0] pending = '0;
    int           last = N - 1;
    int           dly[N];

    always #5 clk = ~clk;

    timer_scheduler #(.NUM_REQ(N), .DELAY_W(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .delay        (delay),
        .done         (done),
        .busy         (busy),
        .grant_id     (grant_id),
        .tmr_AS_L     (tmr_AS_L),
        .tmr_WE_L     (tmr_WE_L),
        .tmr_data_sel (tmr_data_sel),
        .tmr_ctrl_sel (tmr_ctrl_sel),
        .tmr_wdata    (tmr_wdata),
        .tmr_irq      (tmr_irq)
    );

    // External one-shot timer: reload register, control register, irq level at zero count.
    logic [31:0] t_reload = '0;
    logic [31:0] t_cnt = '0;
    logic        t_run = 1'b0;
    assign tmr_irq = t_run && (t_cnt == 32'd0);

    always @(negedge clk) begin
        if (reset) begin
            t_run = 1'b0; t_cnt = '0; t_reload = '0;
        end else if (!tmr_AS_L && !tmr_WE_L && tmr_data_sel) begin
            t_reload = tmr_wdata;
        end else if (!tmr_AS_L && !tmr_WE_L && tmr_ctrl_sel) begin
            t_run = tmr_wdata[0];
            t_cnt = t_reload;
        end else if (t_run && t_cnt != 0) begin
            t_cnt = t_cnt - 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name, input string msg);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Monitor: every strobe and every done pulse is matched against the scoreboard.
    wr_t mon_e;
    int  mon_g;
    always @(negedge clk) begin
        if (!reset) begin
            if (tmr_AS_L) begin
                chk("idle_bus_ctl", 32'({tmr_WE_L, tmr_data_sel, tmr_ctrl_sel}), 32'h4);
                chk("idle_bus_wdata", tmr_wdata, 32'h0);
            end else if (tmr_WE_L) begin
                bad("strobe_no_we", $sformatf("strobe with WE_L high, wdata 0x%0h", tmr_wdata));
            end else if (exp_wr.size() == 0) begin
                bad("unexpected_write", $sformatf("write 0x%0h sel %0b%0b, none expected",
                    tmr_wdata, tmr_data_sel, tmr_ctrl_sel));
            end else begin
                mon_e = exp_wr.pop_front();
                chk("wr_sel", 32'({tmr_data_sel, tmr_ctrl_sel}), mon_e.is_ctrl ? 32'h1 : 32'h2);
                chk("wr_data", tmr_wdata, mon_e.data);
                chk("wr_grant", 32'(grant_id), 32'(mon_e.gid));
            end
            if (done != '0) begin
                if (exp_done.size() == 0) begin
                    bad("unexpected_done", $sformatf("done=0x%0h, none expected", done));
                end else begin
                    mon_g = exp_done.pop_front();
                    chk("done_onehot", 32'(done), 32'(1) << mon_g);
                    chk("done_grant", 32'(grant_id), 32'(mon_g));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference arbitration: first pending index after the last served one, with wrap.
    function automatic int rr_pick(input logic [N-1:0] p, input int ls);
        for (int k = 1; k <= N; k++) begin
            if (p[(ls + k) % N]) return (ls + k) % N;
        end
        return 0;
    endfunction

    task automatic drive_delays();
        for (int i = 0; i < N; i++) delay[i*DW +: DW] = DW'(dly[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pending = '0;
        req = '0;
        step();
        step();
        exp_wr.delete();
        exp_done.delete();
        last = N - 1;
        reset = 1'b0;
    endtask

    task automatic wait_busy(input logic want, input int limit, input string name, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < limit; c++) begin
            step();
            if (busy === want) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) vectors++;
        else bad(name, $sformatf("busy never became %0b within %0d cycles", want, limit));
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_as_l", 32'(tmr_AS_L), 32'h1);
        chk("rst_we_l", 32'(tmr_WE_L), 32'h1);
        chk("rst_data_sel", 32'(tmr_data_sel), 32'h0);
        chk("rst_ctrl_sel", 32'(tmr_ctrl_sel), 32'h0);
        chk("rst_wdata", tmr_wdata, 32'h0);
    endtask

    // One job. mode 0: run to expiry, 1: withdraw during WAIT, 2: withdraw as irq rises.
    task automatic episode(input logic [N-1:0] add, input int fdly, input int mode,
                           input int cwait, input bit keep);
        int  g;
        int  dg;
        bit  ok;
        wr_t w;
        pending |= add;
        if (pending == '0) pending[$urandom_range(0, N-1)] = 1'b1;
        g = rr_pick(pending, last);
        for (int i = 0; i < N; i++) dly[i] = (fdly >= 0) ? fdly : $urandom_range(0, 12);
        if (fdly < 0 && mode == 1) dly[g] = $urandom_range(300, 900);
        if (fdly < 0 && mode == 2) dly[g] = $urandom_range(1, 8);
        dg = dly[g];
        w.gid = g;
        w.is_ctrl = 1'b0; w.data = 32'(dg);  exp_wr.push_back(w);
        w.is_ctrl = 1'b1; w.data = 32'h3;    exp_wr.push_back(w);
        w.is_ctrl = 1'b1; w.data = 32'h0;    exp_wr.push_back(w);
        if (mode != 1) exp_done.push_back(g);
        drive_delays();
        req = pending;
        wait_busy(1'b1, 3, "grant_timeout", ok);
        if (!ok) begin do_reset(); return; end
        // The reload value is already written; new delay inputs must not matter.
        for (int i = 0; i < N; i++) dly[i] = $urandom_range(0, 2000);
        drive_delays();
        case (mode)
            0: begin
                ok = 1'b0;
                for (int c = 0; c < dg + 40; c++) begin
                    step();
                    if (done[g]) begin ok = 1'b1; break; end
                end
                if (!ok) begin bad("done_timeout", $sformatf("no done[%0d]", g)); do_reset(); return; end
                vectors++;
                if (!keep) pending[g] = 1'b0;
                req = pending;
            end
            1: begin
                repeat (cwait) step();
                pending[g] = 1'b0;
                req = pending;
            end
            default: begin
                ok = 1'b0;
                for (int c = 0; c < dg + 40; c++) begin
                    step();
                    if (tmr_irq) begin ok = 1'b1; break; end
                end
                if (!ok) begin bad("irq_timeout", $sformatf("timer never expired for %0d", g)); do_reset(); return; end
                pending[g] = 1'b0;
                req = pending;
                ok = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    step();
                    if (done[g]) begin ok = 1'b1; break; end
                end
                if (!ok) begin bad("tie_done_timeout", $sformatf("no done[%0d] on tie", g)); do_reset(); return; end
                vectors++;
            end
        endcase
        wait_busy(1'b0, 12, "idle_timeout", ok);
        if (!ok) begin do_reset(); return; end
        last = g;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  mode;
        int  g;
        bit  ok;
        wr_t w;

        reset = 1'b1;
        step();
        step();
        check_reset_outputs();
        reset = 1'b0;
        step();

        // Single requester 2, delay 10.
        episode(4'b0100, 10, 0, 0, 1'b0);

        // Contention from reset: all held, all delays 3 -> order 0,1,2,3,0.
        do_reset();
        for (int i = 0; i < 5; i++) episode(4'b1111, 3, 0, 0, 1'b1);
        pending = '0;
        req = '0;

        // Cancel: requester 1, long delay, withdrawn about 20 cycles into WAIT.
        episode(4'b0010, 1000, 1, 22, 1'b0);
        // Tie between expiry and withdrawal.
        episode(4'b0001, 5, 2, 0, 1'b0);
        // Zero delay.
        episode(4'b0001, 0, 0, 0, 1'b0);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            mode = $urandom_range(0, 9);
            mode = (mode < 6) ? 0 : (mode < 8) ? 1 : 2;
            episode(N'($urandom_range(0, (1 << N) - 1)), -1, mode, $urandom_range(2, 25),
                    (mode == 0) && ($urandom_range(0, 1) == 1));
        end
        pending = '0;
        req = '0;

        // Reset while waiting on the timer: no done, no further writes, arbitration restarts at 0.
        g = rr_pick(4'b1000, last);
        for (int i = 0; i < N; i++) dly[i] = 0;
        dly[g] = 500;
        w.gid = g;
        w.is_ctrl = 1'b0; w.data = 32'd500; exp_wr.push_back(w);
        w.is_ctrl = 1'b1; w.data = 32'h3;   exp_wr.push_back(w);
        drive_delays();
        pending = 4'b1000;
        req = pending;
        wait_busy(1'b1, 3, "grant_timeout", ok);
        repeat (6) step();
        reset = 1'b1;
        pending = '0;
        req = '0;
        step();
        check_reset_outputs();
        chk("writes_before_reset", 32'(exp_wr.size()), 32'h0);
        exp_wr.delete();
        exp_done.delete();
        last = N - 1;
        reset = 1'b0;
        repeat (15) step();
        episode(4'b1111, 2, 0, 0, 1'b0);
        pending = '0;
        req = '0;
        repeat (10) step();

        chk("leftover_writes", 32'(exp_wr.size()), 32'h0);
        chk("leftover_done", 32'(exp_done.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_scheduler.md
TIMER_SCHEDULER -- requirements
Module: timer_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DELAY_W, default 32, delay width in timer ticks (<=32).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester level request; held high until done or withdrawn.
REQ-006 SHALL have port delay  input  NUM_REQ*DELAY_W  per-requester delay; slice i = delay[i*DELAY_W +: DELAY_W].
REQ-007 SHALL have port done  output  NUM_REQ  one-cycle completion pulse, one-hot.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port grant_id  output  $clog2(NUM_REQ)  index of the requester currently served.
REQ-010 SHALL have port tmr_AS_L  output  1  timer bus strobe, active-low.
REQ-011 SHALL have port tmr_WE_L  output  1  timer write enable, active-low.
REQ-012 SHALL have port tmr_data_sel  output  1  selects the timer reload register.
REQ-013 SHALL have port tmr_ctrl_sel  output  1  selects the timer control register.
REQ-014 SHALL have port tmr_wdata  output  32  timer write data.
REQ-015 SHALL have port tmr_irq  input  1  timer expiry interrupt, level.

Function
REQ-016 SHALL share one one-shot countdown timer among NUM_REQ requesters, one at a time.
REQ-017 SHALL implement FSM states IDLE, LOAD, START, WAIT, ACK, DONE.
REQ-018 IDLE: if any req high, latch grant via round-robin, go LOAD; else stay.
REQ-019 Round-robin SHALL search from index (last_served+1) mod NUM_REQ upward with wrap; after reset, last_served = NUM_REQ-1, so req[0] has first priority.
REQ-020 LOAD: tmr_AS_L=0, tmr_WE_L=0, tmr_data_sel=1, tmr_wdata = zero-extended delay slice of grant; go START.
REQ-021 START: tmr_AS_L=0, tmr_WE_L=0, tmr_ctrl_sel=1, tmr_wdata=32'h3 (enable + irq enable); go WAIT.
REQ-022 WAIT: bus idle (tmr_AS_L=1, tmr_WE_L=1, selects 0); on tmr_irq=1 set completed flag and go ACK; on req[grant]=0 with tmr_irq=0, clear completed flag and go ACK (cancel).
REQ-023 ACK: tmr_AS_L=0, tmr_WE_L=0, tmr_ctrl_sel=1, tmr_wdata=32'h0 (clears irq, stops timer); go DONE.
REQ-024 DONE: if completed flag set, done[grant]=1 for exactly this cycle; last_served <= grant; go IDLE.
REQ-025 Bus outputs SHALL be registered; tmr_data_sel and tmr_ctrl_sel SHALL never be high together; selects SHALL be 0 whenever tmr_AS_L=1.
REQ-026 tmr_wdata SHALL be 0 in every state other than LOAD and START.
REQ-027 Delay SHALL be sampled only in LOAD; changes to delay inputs afterwards SHALL NOT affect the running operation.
REQ-028 delay=0 SHALL be legal: timer expires without counting; done still pulses.
REQ-029 Simultaneous tmr_irq=1 and req[grant]=0 in WAIT SHALL count as completion (done pulses).
REQ-030 Requests from non-granted requesters SHALL be ignored until IDLE; minimum turnaround is 5 cycles from grant to done, plus timer count time.
REQ-031 A requester holding req high after done SHALL be re-granted only when round-robin reaches it again.
REQ-032 grant_id SHALL hold its value from LOAD through DONE.

Reset
REQ-033 On reset=1 at a clock edge: state=IDLE, busy=0, done=0, grant_id=0, last_served=NUM_REQ-1, completed=0, tmr_AS_L=1, tmr_WE_L=1, both selects 0, tmr_wdata=0.
REQ-034 Reset during any state SHALL abandon the operation with no done pulse; the timer is not written.

Verification
REQ-035 Single: req[2]=1, delay[2]=10 -> LOAD writes 10, START writes 3, done[2] pulses once after tmr_irq, busy then drops.
REQ-036 Contention: req=4'b1111 held, all delays 3 -> done order 0,1,2,3,0, each done one-hot.
REQ-037 Cancel: req[1]=1, delay=1000, drop req[1] 20 cycles into WAIT -> ACK writes 0, no done pulse, return to IDLE.
REQ-038 Tie: tmr_irq rises in the same cycle req[grant] drops -> done[grant] pulses.
REQ-039 Zero delay: req[0]=1, delay[0]=0 -> done[0] pulses with no countdown cycles.
REQ-040 Reset in WAIT -> next cycle all outputs at reset values, no done pulse.
